// File: rtl/dual_ram_arbiter.sv
// dual_ram_arbiter: round-robin sharing of a true-dual-port RAM among NREQ requesters,
// up to two grants per cycle with same-address write conflict blocking.
module dual_ram_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 10,
    parameter int DW   = 16,
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [NREQ*DW-1:0] rsp_rdata,
    output logic [AW-1:0]     ram_addr1,
    output logic [AW-1:0]     ram_addr2,
    output logic [DW-1:0]     ram_data1,
    output logic [DW-1:0]     ram_data2,
    output logic              ram_we1,
    output logic              ram_we2,
    input  logic [DW-1:0]     ram_out1,
    input  logic [DW-1:0]     ram_out2,
    output logic [CW-1:0]     conflict_cnt
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]     ptr, idx, a_idx, b_idx, last_idx;
    logic              a_found, b_found, conflict, grant_b, we_a, we_b;
    logic [AW-1:0]     addr_a, addr_b;
    logic [DW-1:0]     data_a, data_b;
    logic [NREQ-1:0]   one_a, one_b, sel1;
    logic [NREQ*DW-1:0] hold;

    always_comb begin
        idx = '0;
        a_idx = '0;
        b_idx = '0;
        a_found = 1'b0;
        b_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!rst && req_valid[idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx = idx;
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx = idx;
                end
            end
        end
    end

    assign addr_a   = req_addr[a_idx*AW +: AW];
    assign addr_b   = req_addr[b_idx*AW +: AW];
    assign data_a   = req_wdata[a_idx*DW +: DW];
    assign data_b   = req_wdata[b_idx*DW +: DW];
    assign we_a     = req_we[a_idx];
    assign we_b     = req_we[b_idx];
    assign one_a    = NREQ'(1) << a_idx;
    assign one_b    = NREQ'(1) << b_idx;
    // B only competes if it cannot race A on the same word
    assign conflict = b_found && addr_a == addr_b && (we_a || we_b);
    assign grant_b  = b_found && !conflict;
    assign last_idx = grant_b ? b_idx : a_idx;

    assign req_ready = (a_found ? one_a : '0) | (grant_b ? one_b : '0);
    assign ram_addr1 = a_found ? addr_a : '0;
    assign ram_data1 = a_found ? data_a : '0;
    assign ram_we1   = a_found && we_a;
    assign ram_addr2 = grant_b ? addr_b : '0;
    assign ram_data2 = grant_b ? data_b : '0;
    assign ram_we2   = grant_b && we_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            rsp_valid    <= '0;
            sel1         <= '0;
            conflict_cnt <= '0;
        end else begin
            if (a_found)
                ptr <= (last_idx == PW'(NREQ-1)) ? '0 : last_idx + 1'b1;
            sel1         <= (a_found && !we_a) ? one_a : '0;
            rsp_valid    <= ((a_found && !we_a) ? one_a : '0) | ((grant_b && !we_b) ? one_b : '0);
            if (conflict && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) hold <= rsp_rdata;

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        assign rsp_rdata[i*DW +: DW] = rsp_valid[i] ? (sel1[i] ? ram_out1 : ram_out2) : hold[i*DW +: DW];
    end
endmodule

// File: tb/tb_dual_ram_arbiter.sv
// tb_dual_ram_arbiter: directed scenarios plus randomized traffic checked against
// a queue-based round-robin model with its own shadow memory.
module tb_dual_ram_arbiter;
    localparam int NREQ = 4, AW = 10, DW = 16, CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0, req_we = '0, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0, rsp_rdata;
    logic [AW-1:0] ram_addr1, ram_addr2;
    logic [DW-1:0] ram_data1, ram_data2, ram_out1, ram_out2;
    logic ram_we1, ram_we2;
    logic [CW-1:0] conflict_cnt;

    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] mm [1024];
    int m_ptr = 0, m_cnt = 0;
    logic [NREQ-1:0] m_rv = '0, last_ready = '0;
    logic [DW-1:0] m_rd [NREQ];
    bit armed = 0;

    dual_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr1(ram_addr1), .ram_addr2(ram_addr2), .ram_data1(ram_data1), .ram_data2(ram_data2),
        .ram_we1(ram_we1), .ram_we2(ram_we2), .ram_out1(ram_out1), .ram_out2(ram_out2),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_out1 <= ram[ram_addr1];
        ram_out2 <= ram[ram_addr2];
        if (ram_we1) ram[ram_addr1] <= ram_data1;
        if (ram_we2) ram[ram_addr2] <= ram_data2;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] ad(int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wd(int i);
        return req_wdata[i*DW +: DW];
    endfunction

    always @(negedge clk) begin
        int q[$];
        int a, b;
        bit gb, conf;
        logic [NREQ-1:0] er;
        logic [AW-1:0] ea1, ea2;
        logic [DW-1:0] ed1, ed2;
        logic ew1, ew2;
        q.delete();
        for (int k = 0; k < NREQ; k++)
            if (!rst && req_valid[(m_ptr + k) % NREQ]) q.push_back((m_ptr + k) % NREQ);
        a = q.size() > 0 ? q[0] : -1;
        b = q.size() > 1 ? q[1] : -1;
        conf = 0;
        if (b >= 0) conf = ad(a) == ad(b) && (req_we[a] || req_we[b]);
        gb = b >= 0 && !conf;
        er = '0; ea1 = '0; ed1 = '0; ew1 = 0; ea2 = '0; ed2 = '0; ew2 = 0;
        if (a >= 0) begin er[a] = 1; ea1 = ad(a); ed1 = wd(a); ew1 = req_we[a]; end
        if (gb) begin er[b] = 1; ea2 = ad(b); ed2 = wd(b); ew2 = req_we[b]; end
        if (armed) begin
            chk("ready", req_ready, er);
            chk("we1", ram_we1, ew1);
            chk("addr1", ram_addr1, ea1);
            chk("data1", ram_data1, ed1);
            chk("we2", ram_we2, ew2);
            chk("addr2", ram_addr2, ea2);
            chk("data2", ram_data2, ed2);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("conflict_cnt", conflict_cnt, m_cnt);
            for (int i = 0; i < NREQ; i++)
                if (m_rv[i]) chk("rdata", rsp_rdata[i*DW +: DW], m_rd[i]);
        end
        if (rst) begin
            armed = 1;
            m_ptr = 0;
            m_rv = '0;
            m_cnt = 0;
        end else begin
            m_rv = '0;
            if (a >= 0 && !req_we[a]) begin m_rv[a] = 1; m_rd[a] = mm[ad(a)]; end
            if (gb && !req_we[b]) begin m_rv[b] = 1; m_rd[b] = mm[ad(b)]; end
            if (a >= 0 && req_we[a]) mm[ad(a)] = wd(a);
            if (gb && req_we[b]) mm[ad(b)] = wd(b);
            if (conf && m_cnt < CMAX) m_cnt++;
            if (a >= 0) m_ptr = ((gb ? b : a) + 1) % NREQ;
        end
        last_ready = er;
    end

    task automatic set_req(int i, logic v, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[i] = v;
        req_we[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = DW'($urandom);
            mm[i] = ram[i];
        end
        ram[5] = 16'hBEEF; mm[5] = 16'hBEEF;
        ram[7] = 16'h7777; mm[7] = 16'h7777;
        do_reset();
        // single read returns one cycle later on port 1
        set_req(0, 1, 0, 5, 0);
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_addr1", ram_addr1, 5);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rdata0", rsp_rdata[15:0], 16'hBEEF);
        // write/read to the same word: second grant blocked
        do_reset();
        set_req(0, 1, 1, 3, 16'h1234);
        set_req(1, 1, 0, 3, 0);
        @(negedge clk);
        chk("t2_ready_a", req_ready, 4'b0001);
        tick();
        req_valid[0] = 0;
        @(negedge clk);
        chk("t2_ready_b", req_ready, 4'b0010);
        chk("t2_cnt", conflict_cnt, 1);
        tick();
        req_valid[1] = 0;
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid, 4'b0010);
        chk("t2_rdata1", rsp_rdata[31:16], 16'h1234);
        // four readers rotate in pairs
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, AW'(10 + i), 0);
        @(negedge clk);
        chk("t3_pair0", req_ready, 4'b0011);
        tick();
        @(negedge clk);
        chk("t3_pair1", req_ready, 4'b1100);
        chk("t3_rsp0", rsp_valid, 4'b0011);
        tick();
        @(negedge clk);
        chk("t3_pair2", req_ready, 4'b0011);
        chk("t3_rsp1", rsp_valid, 4'b1100);
        tick();
        req_valid = '0;
        // two reads of one address share both ports
        do_reset();
        set_req(2, 1, 0, 7, 0);
        set_req(3, 1, 0, 7, 0);
        @(negedge clk);
        chk("t4_ready", req_ready, 4'b1100);
        chk("t4_addr1", ram_addr1, 7);
        chk("t4_addr2", ram_addr2, 7);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t4_rsp_valid", rsp_valid, 4'b1100);
        chk("t4_rdata2", rsp_rdata[47:32], 16'h7777);
        chk("t4_rdata3", rsp_rdata[63:48], 16'h7777);
        // reset while a read is outstanding
        do_reset();
        set_req(0, 1, 1, 9, 16'h5555);
        set_req(1, 1, 0, 9, 0);
        tick();
        req_valid[0] = 0;
        tick();
        req_valid[1] = 0;
        rst = 1;
        @(negedge clk);
        chk("t5_ready_rst", req_ready, 0);
        chk("t5_we_rst", {ram_we1, ram_we2}, 0);
        tick();
        rst = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, AW'(20 + i), 0);
        @(negedge clk);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_cnt", conflict_cnt, 0);
        chk("t5_ptr0", req_ready, 4'b0011);
        tick();
        req_valid = '0;
        // continuous conflict saturates the counter
        do_reset();
        set_req(0, 1, 1, 1, 16'hAAAA);
        set_req(1, 1, 0, 1, 0);
        repeat (20) tick();
        req_valid = '0;
        @(negedge clk);
        chk("t6_sat", conflict_cnt, 15);
        tick();
        @(negedge clk);
        chk("t6_hold", conflict_cnt, 15);
        // randomized traffic on a small address window to provoke conflicts
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] || last_ready[i])
                    set_req(i, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                            AW'($urandom_range(0, 7)), DW'($urandom));
            rst = $urandom_range(0, 199) == 0;
            tick();
        end
        rst = 0;
        req_valid = '0;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
